// File: rtl/count_display_mux_if.sv
// rtl/count_display_mux_if.sv - count input and display/flag outputs of count_display_mux
interface count_display_mux_if;
  logic [3:0] value;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dir_up;
  logic       step_pulse;
  logic       jump_pulse;

  // Counter side: drives the count, observes the display and flags
  modport master (
    output value,
    input  seg, an, dir_up, step_pulse, jump_pulse
  );

  // Display mux side
  modport slave (
    input  value,
    output seg, an, dir_up, step_pulse, jump_pulse
  );
endinterface

// File: rtl/count_display_mux.sv
// rtl/count_display_mux.sv - count flags plus 2-digit multiplexed 7-segment driver
module count_display_mux #(
  parameter int REFRESH_DIV   = 50000,
  parameter int GAP_CYC       = 16,
  parameter int BLANK_LEADING = 1
) (
  input logic                clk,
  input logic                reset,
  count_display_mux_if.slave bus
);

  // Slot counter must cover the longer of the lit and gap slots
  localparam int MAXL = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
  localparam int CW   = $clog2(MAXL);
  localparam logic [CW-1:0] LIT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [6:0]    SEG_OFF  = 7'h7F;

  typedef enum logic [1:0] {S_UNITS, S_GAP0, S_TENS, S_GAP1} state_t;

  logic [3:0]    r_val_q, r_prev_q, r_disp_q;
  logic          r_fwd, r_bwd, r_oth;
  logic          r_dir_up, r_step, r_jump;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    w_disp_nxt;
  logic [6:0]    r_seg, w_seg_nxt;
  logic [1:0]    r_an, w_an_nxt;
  logic [3:0]    w_diff;
  logic          w_fwd, w_bwd, w_oth;
  logic          w_last;
  logic          w_tens;
  logic [3:0]    w_units;

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_OFF;
    endcase
  endfunction

  // Classify the latest change; the wrap 15<->0 falls out of 4-bit subtraction
  always_comb begin
    w_diff = r_val_q - r_prev_q;
    w_fwd  = (w_diff == 4'd1);
    w_bwd  = (w_diff == 4'hF);
    w_oth  = (w_diff != 4'd0) && !w_fwd && !w_bwd;
  end

  // Input sampling, one classification stage, then the registered flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_val_q  <= 4'd0;
      r_prev_q <= 4'd0;
      r_fwd    <= 1'b0;
      r_bwd    <= 1'b0;
      r_oth    <= 1'b0;
      r_dir_up <= 1'b1;
      r_step   <= 1'b0;
      r_jump   <= 1'b0;
    end else begin
      r_val_q  <= bus.value;
      r_prev_q <= r_val_q;
      r_fwd    <= w_fwd;
      r_bwd    <= w_bwd;
      r_oth    <= w_oth;
      r_step   <= r_fwd | r_bwd;
      r_jump   <= r_oth;
      if (r_fwd) begin
        r_dir_up <= 1'b1;
      end else if (r_bwd) begin
        r_dir_up <= 1'b0;
      end
    end
  end

  // Display FSM next state, plus seg/an for the state being entered
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_disp_nxt  = r_disp_q;
    w_seg_nxt   = SEG_OFF;
    w_an_nxt    = 2'b11;
    w_last      = ((r_state == S_UNITS) || (r_state == S_TENS)) ? (r_cnt == LIT_LAST)
                                                                 : (r_cnt == GAP_LAST);
    if (w_last) begin
      w_cnt_nxt = '0;
      case (r_state)
        S_UNITS: w_state_nxt = S_GAP0;
        S_GAP0:  w_state_nxt = S_TENS;
        S_TENS:  w_state_nxt = S_GAP1;
        default: begin
          w_state_nxt = S_UNITS;
          w_disp_nxt  = r_val_q;
        end
      endcase
    end
    w_tens  = (w_disp_nxt >= 4'd10);
    w_units = w_tens ? (w_disp_nxt - 4'd10) : w_disp_nxt;
    case (w_state_nxt)
      S_UNITS: begin
        w_an_nxt  = 2'b10;
        w_seg_nxt = seg_decode(w_units);
      end
      S_TENS: begin
        if ((BLANK_LEADING != 0) && !w_tens) begin
          w_an_nxt  = 2'b11;
          w_seg_nxt = SEG_OFF;
        end else begin
          w_an_nxt  = 2'b01;
          w_seg_nxt = seg_decode({3'b000, w_tens});
        end
      end
      default: begin
        w_an_nxt  = 2'b11;
        w_seg_nxt = SEG_OFF;
      end
    endcase
  end

  // Display FSM state, slot counter, latched display value and digit drive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_UNITS;
      r_cnt    <= '0;
      r_disp_q <= 4'd0;
      r_seg    <= SEG_OFF;
      r_an     <= 2'b11;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_disp_q <= w_disp_nxt;
      r_seg    <= w_seg_nxt;
      r_an     <= w_an_nxt;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.dir_up     = r_dir_up;
  assign bus.step_pulse = r_step;
  assign bus.jump_pulse = r_jump;

endmodule
